// File: rtl/cfg_pkg.sv
// Shared constants and types for the configuration-word protocol, used by
// both the transmitter and the receiver side.
package cfg_pkg;

  localparam logic [15:0] SYNC_WORD   = 16'hF5A5;
  localparam logic [15:0] UNSYNC_WORD = 16'hFA5A;

  // Receiver register map; start addresses for the header address field.
  localparam logic [5:0] CFG_REG_LAST    = 6'd13;
  localparam logic [5:0] TRIG_MASK_BASE  = 6'd16;
  localparam logic [5:0] TRIG_VALUE_BASE = 6'd20;
  localparam logic [5:0] TRIG_EDGE_BASE  = 6'd24;
  localparam logic [5:0] TRIG_COUNT_BASE = 6'd28;
  localparam logic [5:0] TRIG_LOGIC_BASE = 6'd32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    HDR  = 3'd2,
    DATA = 3'd3,
    EXIT = 3'd4
  } state_t;

  function automatic logic [15:0] hdr_word(input logic [5:0] addr, input logic [7:0] len);
    return {2'b00, addr, len};
  endfunction

endpackage

// File: rtl/cfg_tx_if.sv
// Payload, command and bus signals of the configuration-frame transmitter.
interface cfg_tx_if #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) ();

  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        cmd_valid;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_ready;
  logic        bus_busy;
  logic        usb_en;
  logic        usb_wr;
  logic [15:0] usb_data;
  logic        busy;
  logic        done;
  logic        cmd_err;
  logic [AW:0] fill;

  modport master (
    output wr_valid, wr_data, cmd_valid, cmd_addr, cmd_len, bus_busy,
    input  wr_ready, cmd_ready, usb_en, usb_wr, usb_data, busy, done, cmd_err, fill
  );

  modport slave (
    input  wr_valid, wr_data, cmd_valid, cmd_addr, cmd_len, bus_busy,
    output wr_ready, cmd_ready, usb_en, usb_wr, usb_data, busy, done, cmd_err, fill
  );

endinterface

// File: rtl/cfg_tx_fifo.sv
// Single-clock first-word-fall-through payload FIFO, 16 bits x DEPTH.
module cfg_tx_fifo #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [15:0]   din_i,
  input  logic          pop_i,
  output logic [15:0]   dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   fill_o
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign fill_o  = count_q;
  assign dout_o  = mem[rd_ptr_q];

  // Pushes while full are dropped; wr_ready already told the writer.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/cfg_tx.sv
// Configuration-frame transmitter: buffers payload words and emits atomic
// sync / header / data / unsync frames on the 16-bit usb bus.
module cfg_tx
  import cfg_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic     usb_clk,
  input  logic     usb_rst,
  cfg_tx_if.slave  bus
);

  state_t      state_q, state_d;
  logic [5:0]  addr_q,  addr_d;
  logic [7:0]  len_q,   len_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic        en_q,    en_d;
  logic [15:0] data_q,  data_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        err_q,   err_d;

  logic [15:0] fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_fill;
  logic        pop;
  logic        cmd_invalid;
  logic        cmd_ready;

  cfg_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (usb_clk),
    .rst     (usb_rst),
    .push_i  (bus.wr_valid),
    .din_i   (bus.wr_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fifo_fill)
  );

  // A zero-length header would lock the receiver, so such commands are consumed and flagged.
  assign cmd_invalid = (bus.cmd_len == 8'd0) || ({1'b0, bus.cmd_len} > 9'(DEPTH));
  assign cmd_ready   = (state_q == IDLE) && !bus.bus_busy &&
                       (cmd_invalid || (9'(fifo_fill) >= {1'b0, bus.cmd_len}));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          if (cmd_invalid) begin
            err_d = 1'b1;
          end else begin
            addr_d  = bus.cmd_addr;
            len_d   = bus.cmd_len;
            state_d = SYNC;
          end
        end
      end
      SYNC: state_d = HDR;
      HDR: begin
        state_d = DATA;
        cnt_d   = len_q - 8'd1;
      end
      DATA: begin
        if (cnt_q == 8'd0) state_d = EXIT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      EXIT: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the state being entered.
    en_d   = (state_d != IDLE);
    busy_d = (state_d != IDLE);
    pop    = (state_d == DATA);
    case (state_d)
      SYNC:    data_d = SYNC_WORD;
      HDR:     data_d = hdr_word(addr_q, len_q);
      DATA:    data_d = fifo_dout;
      EXIT:    data_d = UNSYNC_WORD;
      default: data_d = 16'h0000;
    endcase
  end

  always_ff @(posedge usb_clk or posedge usb_rst) begin
    if (usb_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge usb_clk) begin
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  assign bus.wr_ready  = ~fifo_full;
  assign bus.cmd_ready = cmd_ready;
  assign bus.usb_en    = en_q;
  assign bus.usb_wr    = en_q;
  assign bus.usb_data  = data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cmd_err   = err_q;
  assign bus.fill      = fifo_fill;

endmodule

// File: tb/tb_cfg_tx.sv
// Directed self-checking bench for cfg_tx with an 8-deep payload buffer.
module tb_cfg_tx;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic        en_a   [16];
  logic [15:0] data_a [16];
  logic        done_a [16];
  logic        busy_a [16];

  always #5 clk = ~clk;

  cfg_tx_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  cfg_tx #(.DEPTH(DEPTH), .AW(AW)) dut (
    .usb_clk (clk),
    .usb_rst (rst),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  // Records the bus for n cycles starting with the current one.
  task automatic capture(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      en_a[base+i]   = bus.usb_en;
      data_a[base+i] = bus.usb_data;
      done_a[base+i] = bus.done;
      busy_a[base+i] = bus.busy;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.usb_en, bus.usb_wr, bus.usb_data, bus.busy, bus.done, bus.cmd_err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b wr=%b data=%h busy=%b done=%b err=%b want all 0",
               bus.usb_en, bus.usb_wr, bus.usb_data, bus.busy, bus.done, bus.cmd_err);
    end
    checks++;
    if (bus.fill !== 4'd0 || bus.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_fill got fill=%0d wr_ready=%b want 0/1", bus.fill, bus.wr_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [15:0] exp [4];
    exp = '{16'hF5A5, 16'h0001, 16'h0001, 16'hFA5A};
    push(16'h0001);
    bus.cmd_addr = 6'd0; bus.cmd_len = 8'd1; bus.cmd_valid = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready got %b want 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
    capture(0, 6);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (en_a[i] !== 1'b1 || data_a[i] !== exp[i] || busy_a[i] !== 1'b1 || done_a[i] !== 1'b0) begin
        errors++;
        $display("FAIL single_word%0d got en=%b data=%h busy=%b done=%b want 1/%h/1/0",
                 i, en_a[i], data_a[i], busy_a[i], done_a[i], exp[i]);
      end
    end
    checks++;
    if (en_a[4] !== 1'b0 || data_a[4] !== 16'h0000 || done_a[4] !== 1'b1 || busy_a[4] !== 1'b0) begin
      errors++;
      $display("FAIL single_end got en=%b data=%h done=%b busy=%b want 0/0000/1/0",
               en_a[4], data_a[4], done_a[4], busy_a[4]);
    end
    checks++;
    if (done_a[5] !== 1'b0) begin
      errors++; $display("FAIL single_done_pulse got %b want 0", done_a[5]);
    end
  endtask

  task automatic test_multi();
    logic [15:0] exp [6];
    int          en_cnt;
    exp = '{16'hF5A5, 16'h0303, 16'h1234, 16'h5678, 16'h9ABC, 16'hFA5A};
    push(16'h1234); push(16'h5678); push(16'h9ABC);
    checks++;
    if (bus.fill !== 4'd3) begin
      errors++; $display("FAIL multi_fill got %0d want 3", bus.fill);
    end
    bus.cmd_addr = 6'd3; bus.cmd_len = 8'd3; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    capture(0, 9);
    en_cnt = 0;
    for (int i = 0; i < 9; i++) if (en_a[i] === 1'b1) en_cnt++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (en_a[i] !== 1'b1 || data_a[i] !== exp[i]) begin
        errors++;
        $display("FAIL multi_word%0d got en=%b data=%h want 1/%h", i, en_a[i], data_a[i], exp[i]);
      end
    end
    checks++;
    if (en_cnt != 6 || done_a[6] !== 1'b1) begin
      errors++; $display("FAIL multi_en_len got en_cycles=%0d done=%b want 6/1", en_cnt, done_a[6]);
    end
  endtask

  task automatic test_invalid();
    int en_seen;
    logic [7:0] lens [2];
    lens = '{8'd0, 8'd9};
    en_seen = 0;
    for (int k = 0; k < 2; k++) begin
      bus.cmd_addr = 6'd1; bus.cmd_len = lens[k]; bus.cmd_valid = 1'b1;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
        errors++; $display("FAIL invalid_ready len=%0d got %b want 1", lens[k], bus.cmd_ready);
      end
      tick();
      bus.cmd_valid = 1'b0;
      if (bus.usb_en === 1'b1) en_seen++;
      checks++;
      if (bus.cmd_err !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL invalid_err len=%0d got err=%b busy=%b want 1/0", lens[k], bus.cmd_err, bus.busy);
      end
      tick();
      if (bus.usb_en === 1'b1) en_seen++;
    end
    checks++;
    if (bus.cmd_err !== 1'b0 || en_seen != 0) begin
      errors++; $display("FAIL invalid_quiet got err=%b en_cycles=%0d want 0/0", bus.cmd_err, en_seen);
    end
  endtask

  task automatic test_holdoff();
    logic [15:0] exp [7];
    int          waited;
    exp = '{16'hF5A5, 16'h1004, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hFA5A};
    push(16'hA001); push(16'hA002);
    bus.cmd_addr = 6'd16; bus.cmd_len = 8'd4; bus.cmd_valid = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL holdoff_short got ready=%b want 0", bus.cmd_ready);
    end
    push(16'hA003);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.usb_en !== 1'b0) begin
      errors++; $display("FAIL holdoff_three got ready=%b en=%b want 0/0", bus.cmd_ready, bus.usb_en);
    end
    bus.wr_valid = 1'b1; bus.wr_data = 16'hA004;
    @(posedge clk);
    bus.bus_busy = 1'b1;
    #1;
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.fill !== 4'd4 || bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL holdoff_busy got fill=%0d ready=%b want 4/0", bus.fill, bus.cmd_ready);
    end
    tick(); tick(); tick();
    checks++;
    if (bus.usb_en !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL holdoff_idle got en=%b busy=%b want 0/0", bus.usb_en, bus.busy);
    end
    bus.bus_busy = 1'b0;
    waited = 0;
    #1;
    while (bus.cmd_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL holdoff_accept_timeout got ready=%b want 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
    bus.bus_busy  = 1'b1;
    capture(0, 8);
    bus.bus_busy  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (en_a[i] !== 1'b1 || data_a[i] !== exp[i]) begin
        errors++;
        $display("FAIL holdoff_word%0d got en=%b data=%h want 1/%h", i, en_a[i], data_a[i], exp[i]);
      end
    end
    checks++;
    if (en_a[7] !== 1'b0 || done_a[7] !== 1'b1) begin
      errors++; $display("FAIL holdoff_end got en=%b done=%b want 0/1", en_a[7], done_a[7]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [10];
    exp = '{16'hF5A5, 16'h0501, 16'h00AA, 16'hFA5A, 16'h0000,
            16'hF5A5, 16'h0501, 16'h00BB, 16'hFA5A, 16'h0000};
    push(16'h00AA); push(16'h00BB);
    bus.cmd_addr = 6'd5; bus.cmd_len = 8'd1; bus.cmd_valid = 1'b1;
    tick();
    capture(0, 5);
    bus.cmd_valid = 1'b0;
    capture(5, 5);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (data_a[i] !== exp[i] || en_a[i] !== (i != 4 && i != 9)) begin
        errors++;
        $display("FAIL b2b_word%0d got en=%b data=%h want %b/%h", i, en_a[i], data_a[i],
                 (i != 4 && i != 9), exp[i]);
      end
    end
  endtask

  task automatic test_full_reset();
    for (int i = 0; i < DEPTH; i++) push(16'hB000 + 16'(i));
    checks++;
    if (bus.fill !== 4'd8 || bus.wr_ready !== 1'b0) begin
      errors++; $display("FAIL full_level got fill=%0d wr_ready=%b want 8/0", bus.fill, bus.wr_ready);
    end
    push(16'hB0FF);
    checks++;
    if (bus.fill !== 4'd8) begin
      errors++; $display("FAIL full_overflow got fill=%0d want 8", bus.fill);
    end
    bus.cmd_addr = 6'd0; bus.cmd_len = 8'd8; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_data = 16'hC000;
    tick();
    tick();
    // Now in the first DATA cycle.
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.fill !== 4'd7 || bus.usb_data !== 16'hB000) begin
      errors++;
      $display("FAIL full_first_pop got wr_ready=%b fill=%0d data=%h want 1/7/b000",
               bus.wr_ready, bus.fill, bus.usb_data);
    end
    tick();
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.fill !== 4'd7 || bus.usb_data !== 16'hB001) begin
      errors++; $display("FAIL full_push_pop got fill=%0d data=%h want 7/b001", bus.fill, bus.usb_data);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.usb_en, bus.usb_wr, bus.usb_data, bus.busy, bus.done, bus.cmd_err} !== 21'd0 ||
        bus.fill !== 4'd0) begin
      errors++;
      $display("FAIL midframe_reset got en=%b data=%h busy=%b fill=%0d want 0/0000/0/0",
               bus.usb_en, bus.usb_data, bus.busy, bus.fill);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.usb_en !== 1'b0 || bus.fill !== 4'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got en=%b fill=%0d busy=%b want 0/0/0", bus.usb_en, bus.fill, bus.busy);
    end
  endtask

  initial begin
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 16'h0000;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 6'd0;
    bus.cmd_len   = 8'd0;
    bus.bus_busy  = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_invalid();
    test_holdoff();
    test_back_to_back();
    test_full_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
